rr_sel_mux_reg: RTL and testbench

//  - Parametrised N-way, WIDTH-bit registered selector with valid/ready handshakes on every port.
//  - Generalises the fixed 2:1 datapath select: N channels, a registered output stage and a selectable arbitration mode.
//  - Used in the CPU datapath where several producers compete for one consumer.
//  - Examples: write-back source selection, register-address select, shared-bus request merging.

---
 rtl/rr_sel_mux_reg.sv | 80 ++++++++
 tb/tb_rr_sel_mux_reg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_mux_reg.sv
// N-way registered selector: explicit sel (MODE=0) or round-robin (MODE=1) grant into a
// single-entry output register. 1 clk latency; in_ready drops while out_valid & !out_ready.
module rr_sel_mux_reg #(
  parameter int WIDTH = 5,
  parameter int N     = 2,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gidx;
  logic [SELW-1:0]  idx;
  logic             found;
  logic [WIDTH-1:0] sel_data;
  logic             can_acc;
  logic             xfer;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        grant[sel] = in_valid[sel];
        gidx       = sel;
      end
    end else begin
      // Scan rr_ptr, rr_ptr+1, ... wrapping; the first valid channel wins.
      for (int k = 0; k < N; k++) begin
        idx = SELW'((int'(rr_ptr) + k) % N);
        if (!found && in_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = idx;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign can_acc  = !out_valid || out_ready;
  assign in_ready = rst_n ? (grant & {N{can_acc}}) : '0;
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= gidx;
      if (MODE != 0) rr_ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_sel_mux_reg.sv
// Directed bench for rr_sel_mux_reg: three configurations, expected words queued at issue
// and popped by a monitor on each output handshake.
module tb_rr_sel_mux_reg;

  typedef struct packed {
    logic [1:0] ch;
    logic [4:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: MODE=1 N=4
  logic [3:0]  a_in_valid, a_in_ready;
  logic [19:0] a_in_data;
  logic [1:0]  a_sel, a_out_ch;
  logic        a_out_valid, a_out_ready;
  logic [4:0]  a_out_data;
  // b: MODE=0 N=2
  logic [1:0]  b_in_valid, b_in_ready;
  logic [9:0]  b_in_data;
  logic        b_sel, b_out_ch;
  logic        b_out_valid, b_out_ready;
  logic [4:0]  b_out_data;
  // c: MODE=0 N=3
  logic [2:0]  c_in_valid, c_in_ready;
  logic [14:0] c_in_data;
  logic [1:0]  c_sel, c_out_ch;
  logic        c_out_valid, c_out_ready;
  logic [4:0]  c_out_data;

  rr_sel_mux_reg #(.WIDTH(5), .N(4), .MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .sel(a_sel), .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch), .out_ready(a_out_ready));
  rr_sel_mux_reg #(.WIDTH(5), .N(2), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .sel(b_sel), .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch), .out_ready(b_out_ready));
  rr_sel_mux_reg #(.WIDTH(5), .N(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .sel(c_sel), .out_valid(c_out_valid), .out_data(c_out_data), .out_ch(c_out_ch), .out_ready(c_out_ready));

  exp_t qa[$], qb[$], qc[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && a_out_ready) begin
      chk("a_pending", qa.size() != 0, 1);
      if (qa.size() != 0) begin e = qa.pop_front(); chk("a_out", {a_out_ch, a_out_data}, e); end
    end
    if (b_out_valid && b_out_ready) begin
      chk("b_pending", qb.size() != 0, 1);
      if (qb.size() != 0) begin e = qb.pop_front(); chk("b_out", {1'b0, b_out_ch, b_out_data}, e); end
    end
    if (c_out_valid && c_out_ready) begin
      chk("c_pending", qc.size() != 0, 1);
      if (qc.size() != 0) begin e = qc.pop_front(); chk("c_out", {c_out_ch, c_out_data}, e); end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 4'hF; a_in_data = '0; a_sel = '0; a_out_ready = 1'b0;
    b_in_valid = 2'b11; b_in_data = '0; b_sel = '0; b_out_ready = 1'b0;
    c_in_valid = 3'b111; c_in_data = '0; c_sel = '0; c_out_ready = 1'b0;
    #12;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_out_ch", a_out_ch, 0);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_c_in_ready", c_in_ready, 0);
    tick();
    a_in_valid = '0; b_in_valid = '0; c_in_valid = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    rst_n = 1'b1;
    tick();

    // MODE=0 N=2 explicit select
    b_sel = 1'b1; b_in_data = {5'h1A, 5'h05}; b_in_valid = 2'b11;
    #1 chk("b_in_ready_sel1", b_in_ready, 2'b10);
    qb.push_back(exp_t'({2'd1, 5'h1A}));
    tick();
    b_in_valid = '0;
    #1 chk("b_out_data", b_out_data, 5'h1A);
    chk("b_out_ch", b_out_ch, 1);
    tick();
    chk("b_drained", b_out_valid, 0);

    // sel change while stalled, then drain+fill follows the new sel
    b_out_ready = 1'b0; b_sel = 1'b0; b_in_data = {5'h1A, 5'h09}; b_in_valid = 2'b01;
    qb.push_back(exp_t'({2'd0, 5'h09}));
    tick();
    b_sel = 1'b1; b_in_valid = 2'b11;
    #1 chk("b_stall_in_ready", b_in_ready, 2'b00);
    chk("b_stall_data", b_out_data, 5'h09);
    b_out_ready = 1'b1;
    #1 chk("b_newsel_in_ready", b_in_ready, 2'b10);
    qb.push_back(exp_t'({2'd1, 5'h1A}));
    tick();
    b_in_valid = '0;
    chk("b_reload_data", b_out_data, 5'h1A);
    tick();

    // MODE=1 N=4 fairness: 0,1,2,3,0,1,2,3 with no gaps
    a_in_data = {5'h13, 5'h12, 5'h11, 5'h10}; a_in_valid = 4'hF;
    #1 chk("a_first_grant", a_in_ready, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      qa.push_back(exp_t'({2'(k % 4), 5'(16 + k % 4)}));
      if (k > 0) chk("a_continuous", a_out_valid, 1);
      tick();
    end
    a_in_valid = '0;
    tick();

    // Backpressure: hold 0C for 3 stalled clocks, rr_ptr must stay at 2
    a_out_ready = 1'b0; a_in_data = {5'h13, 5'h15, 5'h0C, 5'h10}; a_in_valid = 4'b0010;
    qa.push_back(exp_t'({2'd1, 5'h0C}));
    tick();
    a_in_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1 chk("a_bp_in_ready", a_in_ready, 0);
      chk("a_bp_data", a_out_data, 5'h0C);
      chk("a_bp_valid", a_out_valid, 1);
      tick();
    end
    a_out_ready = 1'b1;
    #1 chk("a_bp_resume_grant", a_in_ready, 4'b0100);
    qa.push_back(exp_t'({2'd2, 5'h15}));
    tick();
    a_in_valid = '0;
    chk("a_no_bubble_valid", a_out_valid, 1);
    chk("a_no_bubble_data", a_out_data, 5'h15);
    chk("a_no_bubble_ch", a_out_ch, 2);
    tick();

    // MODE=0 N=3 out-of-range sel
    c_sel = 2'd0; c_in_data = {5'h0B, 5'h0A, 5'h07}; c_in_valid = 3'b001;
    qc.push_back(exp_t'({2'd0, 5'h07}));
    tick();
    c_sel = 2'd3; c_in_valid = 3'b111;
    #1 chk("c_oob_in_ready", c_in_ready, 0);
    chk("c_holding", c_out_valid, 1);
    tick();
    chk("c_oob_in_ready2", c_in_ready, 0);
    chk("c_drained", c_out_valid, 0);
    c_in_valid = '0;

    // Async reset mid-burst; rr_ptr is 3 on entry
    a_in_data = {5'h1D, 5'h1C, 5'h1B, 5'h1E}; a_in_valid = 4'hF;
    qa.push_back(exp_t'({2'd3, 5'h1D}));
    tick();
    qa.push_back(exp_t'({2'd0, 5'h1E}));
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1 chk("arst_out_valid", a_out_valid, 0);
    chk("arst_out_data", a_out_data, 0);
    chk("arst_out_ch", a_out_ch, 0);
    chk("arst_in_ready", a_in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("arst_restart_grant", a_in_ready, 4'b0001);
    qa.push_back(exp_t'({2'd0, 5'h1E}));
    tick();
    qa.push_back(exp_t'({2'd1, 5'h1B}));
    tick();
    a_in_valid = '0;
    tick();
    tick();

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
